count_checker: RTL and testbench
================================

# count_checker

Sequence checker that consumes the free-running count stream produced by the demo counters and verifies that every valid sample equals the previous sample plus STEP, modulo 2^WIDTH. It acquires lock after LOCK_N consecutive correct samples and reports each post-lock discontinuity as a one-cycle error pulse. It also keeps a saturating error tally. It sits downstream of any counter source in a testbench or FPGA demo, as the reading end of the count stream.

## Interface
- WIDTH, 8, width of count samples
- STEP, 1, expected increment per valid sample (modulo 2^WIDTH)
- LOCK_N, 4, consecutive correct samples required to assert lock (≥1)
- ERR_W, 16, width of error tally
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  asynchronous, active-low reset
- count_in  input  WIDTH  sample from the counter source
- count_valid  input  1  count_in is a sample this cycle
- err_clr  input  1  synchronous clear of err_count
- locked  output  1  checker is in LOCKED state
- error  output  1  one-cycle pulse per mismatch seen while locked
- err_count  output  ERR_W  saturating mismatch tally
- expected  output  WIDTH  value required of the next valid sample

## Operation
- States: IDLE=0, ACQUIRE=1, LOCKED=2. Value 3 is unreachable and recovers to IDLE.
- Expected value: expected = last accepted sample + STEP, truncated to WIDTH bits. 0xFF + 1 gives 0x00, which is a match and not an error.
- IDLE, count_valid=1: capture the sample, set match_cnt=0, go to ACQUIRE.
- ACQUIRE, valid and match: match_cnt+1, capture the sample. When match_cnt reaches LOCK_N, go to LOCKED.
- ACQUIRE, valid and mismatch: resync (capture the sample, match_cnt=0). No error pulse, no tally change.
- LOCKED, valid and match: capture the sample, stay in LOCKED.
- LOCKED, valid and mismatch: error=1 for one cycle, err_count+1 (saturating at 2^ERR_W−1), resync, go to ACQUIRE.
- count_valid=0: state, match_cnt, expected and err_count are held. Only err_clr acts, and error is 0.
- err_clr=1 sets err_count to 0. If err_clr and a locked mismatch occur in the same cycle, err_count becomes 1 and error still pulses.
- Reset values: state=IDLE, locked=0, error=0, err_count=0, expected=0, match_cnt=0.

## Timing
- All outputs are registered; nothing is combinational from the inputs.
- A sample taken at edge N updates locked, error, err_count and expected after edge N. They are visible during cycle N+1.
- Lock latency: the first sample is followed by LOCK_N matching samples, so locked rises after the (LOCK_N+1)-th valid sample edge.
- Valid gaps do not break the lock count.
- rst_n is asserted asynchronously and clears all state immediately.
- Reset deassertion is assumed synchronized upstream.
- Reset mid-acquire or mid-lock drops to IDLE. The first post-reset sample is a capture and never an error.
- error is never high for two consecutive cycles, because a mismatch always exits LOCKED.

## Structure
- Shared package count_checker_pkg holds:
  - the state encodings IDLE, ACQUIRE, LOCKED (2-bit);
  - the localparam width for match_cnt: clog2(LOCK_N+1).
- One natural sub-module: sat_counter (parameter W; inputs inc, clr; clr-then-inc semantics) for err_count.
- The FSM and compare logic stay in count_checker.

## Test plan
- Clean stream: after reset, drive count_valid=1 every cycle with count_in=0,1,2,… (LOCK_N=4).
  - locked rises in the cycle after sample value 4.
  - error stays 0.
  - err_count=0 through 300 samples, including the wrap 0xFF→0x00.
- Single glitch while locked: drive …,10,11,99,100,101,… .
  - error pulses once in the cycle after 99, err_count=1, locked falls.
  - locked rises again after sample 103 (99 plus 4 matches).
- Glitch during acquire: drive 5,6,40,41,42,43,44.
  - error is never asserted and err_count=0.
  - locked rises after 44.
- Valid gaps: drive the incrementing stream with count_valid toggling 1,0,0,1.
  - Lock is still reached after 5 valid samples.
  - expected holds during the gaps.
- Saturation and clear: ERR_W=2, force 5 locked mismatches.
  - err_count saturates at 3.
  - err_clr coincident with a further mismatch gives err_count=1, error=1.
- Async reset mid-lock: assert rst_n=0 between edges while locked.
  - locked, error, err_count and expected go to 0 immediately, without waiting for a clock edge.
  - After release, sample 57 gives no error and expected=58.

Source files
------------

// File: rtl/count_checker_pkg.sv
// rtl/count_checker_pkg.sv - shared state encodings and sizing helpers for count_checker
package count_checker_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam int LOCK_N_DEFAULT = 4;
    localparam int MATCH_CNT_W    = $clog2(LOCK_N_DEFAULT + 1);

    // Width needed to hold match counts 0..lock_n inclusive.
    function automatic int match_cnt_width(input int lock_n);
        return (lock_n < 1) ? 1 : $clog2(lock_n + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear taking priority over increment
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear happens first, so clear plus increment in one cycle lands on 1.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = W'(inc);
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/count_checker.sv
// rtl/count_checker.sv - checks that each valid count sample equals the previous one plus STEP
module count_checker
    import count_checker_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP   = 1,
    parameter int LOCK_N = 4,
    parameter int ERR_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             error,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected
);

    localparam int               CNT_W  = match_cnt_width(LOCK_N);
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
    localparam logic [CNT_W-1:0] LOCK_V = CNT_W'(LOCK_N);

    state_e             state_q;
    logic [CNT_W-1:0]   match_cnt_q;
    logic [WIDTH-1:0]   expected_q;
    logic               locked_q;
    logic               error_q;

    logic               sample_match;
    logic               lock_miss;
    logic [WIDTH-1:0]   expected_d;
    logic [CNT_W-1:0]   match_cnt_inc;

    assign sample_match  = (count_in == expected_q);
    assign lock_miss     = count_valid && (state_q == LOCKED) && !sample_match;
    assign expected_d    = count_in + STEP_V;
    assign match_cnt_inc = match_cnt_q + 1'b1;

    // Every valid sample is captured, so a mismatch resyncs to the new stream position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            match_cnt_q <= '0;
            expected_q  <= '0;
            locked_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (count_valid) begin
                        expected_q  <= expected_d;
                        match_cnt_q <= '0;
                        locked_q    <= 1'b0;
                        state_q     <= ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (count_valid) begin
                        expected_q <= expected_d;
                        if (sample_match) begin
                            match_cnt_q <= match_cnt_inc;
                            if (match_cnt_inc == LOCK_V) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            match_cnt_q <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (count_valid) begin
                        expected_q <= expected_d;
                        if (!sample_match) begin
                            error_q     <= 1'b1;
                            locked_q    <= 1'b0;
                            match_cnt_q <= '0;
                            state_q     <= ACQUIRE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    match_cnt_q <= '0;
                    locked_q    <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_tally (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (lock_miss),
        .clr   (err_clr),
        .count (err_count)
    );

    assign locked   = locked_q;
    assign error    = error_q;
    assign expected = expected_q;

endmodule

// File: tb/tb_count_checker.sv
// tb/tb_count_checker.sv - self-checking bench for count_checker
module tb_count_checker;

    logic        clk;
    logic        rst_n;
    logic [7:0]  count_in;
    logic        count_valid;
    logic        err_clr;
    logic        locked;
    logic        error;
    logic [15:0] err_count;
    logic [7:0]  expected;
    logic        locked_s;
    logic        error_s;
    logic [1:0]  err_count_s;
    logic [7:0]  expected_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        locked;
        logic        error;
        logic [15:0] cnt;
        logic [7:0]  exp;
    } exp_t;

    typedef struct {
        bit          rst;
        logic [7:0]  cin;
        logic        v;
        logic        clr;
        logic        locked;
        logic        error;
        logic [15:0] cnt;
        logic [7:0]  exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    count_checker dut (
        .clk(clk), .rst_n(rst_n), .count_in(count_in), .count_valid(count_valid),
        .err_clr(err_clr), .locked(locked), .error(error), .err_count(err_count),
        .expected(expected)
    );

    count_checker #(.ERR_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .count_in(count_in), .count_valid(count_valid),
        .err_clr(err_clr), .locked(locked_s), .error(error_s), .err_count(err_count_s),
        .expected(expected_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: no expectation queued at t=%0t", $time);
        end else begin
            e = sb.pop_front();
            chk("locked", 32'(locked), 32'(e.locked));
            chk("error", 32'(error), 32'(e.error));
            chk("err_count", 32'(err_count), 32'(e.cnt));
            chk("expected", 32'(expected), 32'(e.exp));
            chk("sat_err_count", 32'(err_count_s), (e.cnt > 16'd3) ? 32'd3 : 32'(e.cnt));
        end
    endtask

    task automatic step(input logic [7:0] cin, input logic v, input logic clr,
                        input logic el, input logic ee, input logic [15:0] ec, input logic [7:0] ex);
        exp_t e;
        count_in    = cin;
        count_valid = v;
        err_clr     = clr;
        e.locked = el; e.error = ee; e.cnt = ec; e.exp = ex;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic do_reset();
        count_valid = 1'b0;
        err_clr     = 1'b0;
        rst_n       = 1'b0;
        #2;
        rst_n       = 1'b1;
    endtask

    initial begin
        logic [7:0] cur;

        // glitch while locked
        vecs.push_back('{1'b1, 8'd10,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd11});
        vecs.push_back('{1'b0, 8'd11,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd12});
        vecs.push_back('{1'b0, 8'd12,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd13});
        vecs.push_back('{1'b0, 8'd13,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd14});
        vecs.push_back('{1'b0, 8'd14,  1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd15});
        vecs.push_back('{1'b0, 8'd15,  1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd16});
        vecs.push_back('{1'b0, 8'd99,  1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 8'd100});
        vecs.push_back('{1'b0, 8'd100, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 8'd101});
        vecs.push_back('{1'b0, 8'd101, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 8'd102});
        vecs.push_back('{1'b0, 8'd102, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 8'd103});
        vecs.push_back('{1'b0, 8'd103, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 8'd104});
        vecs.push_back('{1'b0, 8'd104, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 8'd105});
        vecs.push_back('{1'b0, 8'd200, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 8'd105});
        vecs.push_back('{1'b0, 8'd201, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 8'd105});
        // glitch during acquire
        vecs.push_back('{1'b1, 8'd5,   1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd6});
        vecs.push_back('{1'b0, 8'd6,   1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd7});
        vecs.push_back('{1'b0, 8'd40,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd41});
        vecs.push_back('{1'b0, 8'd41,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd42});
        vecs.push_back('{1'b0, 8'd42,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd43});
        vecs.push_back('{1'b0, 8'd43,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd44});
        vecs.push_back('{1'b0, 8'd44,  1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd45});
        vecs.push_back('{1'b0, 8'd45,  1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd46});
        // valid gaps 1,0,0,1
        vecs.push_back('{1'b1, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd1});
        vecs.push_back('{1'b0, 8'd77,  1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd1});
        vecs.push_back('{1'b0, 8'd88,  1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd1});
        vecs.push_back('{1'b0, 8'd1,   1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd2});
        vecs.push_back('{1'b0, 8'd2,   1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd3});
        vecs.push_back('{1'b0, 8'd55,  1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd3});
        vecs.push_back('{1'b0, 8'd66,  1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd3});
        vecs.push_back('{1'b0, 8'd3,   1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd4});
        vecs.push_back('{1'b0, 8'd4,   1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd5});
        vecs.push_back('{1'b0, 8'd99,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 8'd5});

        rst_n       = 1'b0;
        count_in    = '0;
        count_valid = 1'b0;
        err_clr     = 1'b0;
        #22;
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_error", 32'(error), 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);
        chk("reset_expected", 32'(expected), 32'd0);
        chk("reset_sat_err_count", 32'(err_count_s), 32'd0);
        rst_n = 1'b1;

        // clean stream including the 0xFF -> 0x00 wrap
        for (int i = 0; i < 300; i++) begin
            step(8'(i), 1'b1, 1'b0, (i >= 4), 1'b0, 16'd0, 8'(i + 1));
        end

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            step(vecs[k].cin, vecs[k].v, vecs[k].clr,
                 vecs[k].locked, vecs[k].error, vecs[k].cnt, vecs[k].exp);
        end

        // saturation: five locked mismatches, then clear coincident with a sixth
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(8'(i), 1'b1, 1'b0, (i == 4), 1'b0, 16'd0, 8'(i + 1));
        end
        cur = 8'd5;
        for (int k = 1; k <= 5; k++) begin
            cur = cur + 8'd100;
            step(cur, 1'b1, 1'b0, 1'b0, 1'b1, 16'(k), cur + 8'd1);
            cur = cur + 8'd1;
            for (int j = 1; j <= 4; j++) begin
                step(cur, 1'b1, 1'b0, (j == 4), 1'b0, 16'(k), cur + 8'd1);
                cur = cur + 8'd1;
            end
        end
        cur = cur + 8'd50;
        step(cur, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1, cur + 8'd1);
        cur = cur + 8'd1;
        for (int j = 1; j <= 4; j++) begin
            step(cur, 1'b1, 1'b0, (j == 4), 1'b0, 16'd1, cur + 8'd1);
            cur = cur + 8'd1;
        end

        // asynchronous reset between edges while locked
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_locked", 32'(locked), 32'd0);
        chk("async_error", 32'(error), 32'd0);
        chk("async_err_count", 32'(err_count), 32'd0);
        chk("async_expected", 32'(expected), 32'd0);
        chk("async_sat_err_count", 32'(err_count_s), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'd57, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd58);
        step(8'd58, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd59);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
